// File: rtl/fma16_dot_seq_if.sv
// Bus bundle for the fma16 dot-product sequencer: job request, element
// stream, result handshake and the pins of the fma16 datapath it drives.
// master is the environment side (source, sink and fma16); slave is the sequencer.
interface fma16_dot_seq_if #(
    parameter int LEN_W = 8
);
    // Job request
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      init;
    logic [1:0]       roundmode_in;
    logic             neg_in;
    // Element stream
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_x;
    logic [15:0]      in_y;
    // Result handshake
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic [3:0]       out_flags;
    logic             busy;
    // fma16 datapath pins
    logic [15:0]      fma_x;
    logic [15:0]      fma_y;
    logic [15:0]      fma_z;
    logic             fma_mul;
    logic             fma_add;
    logic             fma_negp;
    logic             fma_negz;
    logic [1:0]       fma_roundmode;
    logic [15:0]      fma_result;
    logic [3:0]       fma_flags;

    modport master (
        output start, len, init, roundmode_in, neg_in,
        output in_valid, in_x, in_y, out_ready,
        output fma_result, fma_flags,
        input  in_ready, out_valid, out_result, out_flags, busy,
        input  fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode
    );

    modport slave (
        input  start, len, init, roundmode_in, neg_in,
        input  in_valid, in_x, in_y, out_ready,
        input  fma_result, fma_flags,
        output in_ready, out_valid, out_result, out_flags, busy,
        output fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode
    );
endinterface

// File: rtl/fma16_dot_seq.sv
// fma16_dot_seq: drives one combinational fma16 through a half-precision
// dot product acc = init + sum(+/- x[i]*y[i]). Each accepted pair issues one
// fused multiply-add with z taken from the accumulator, so rounding happens
// once per element in strict arrival order.
module fma16_dot_seq #(
    parameter int LEN_W = 8
) (
    input logic            clk,
    input logic            reset,
    fma16_dot_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [15:0]      acc, acc_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [3:0]       flg, flg_nx;
    logic [1:0]       rm_r, rm_nx;
    logic             neg_r, neg_nx;
    logic             accept;

    // A pair is consumed only while running; in_ready is exactly state==RUN.
    assign accept = (state == RUN) && bus.in_valid;

    // State and job registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            flg   <= '0;
            rm_r  <= '0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            flg   <= flg_nx;
            rm_r  <= rm_nx;
            neg_r <= neg_nx;
        end
    end

    // Next-state and job register updates. Mode is latched at start so a
    // caller changing roundmode_in/neg_in mid-job cannot disturb it.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        flg_nx   = flg;
        rm_nx    = rm_r;
        neg_nx   = neg_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nx   = bus.init;
                    cnt_nx   = bus.len;
                    flg_nx   = 4'b0000;
                    rm_nx    = bus.roundmode_in;
                    neg_nx   = bus.neg_in;
                    // Empty job skips RUN; result is init with clean flags.
                    state_nx = (bus.len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_nx = bus.fma_result;
                    flg_nx = flg | bus.fma_flags;
                    // cnt>=1 throughout RUN, so this never wraps.
                    cnt_nx = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                // start in the same cycle is deliberately dropped.
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Handshake, result and fma16 pins. Results come straight from registers,
    // so nothing on in_* reaches out_* combinationally.
    always_comb begin
        bus.in_ready      = (state == RUN);
        bus.out_valid     = (state == DONE);
        bus.busy          = (state != IDLE);
        bus.out_result    = acc;
        bus.out_flags     = flg;
        // Operands are zeroed outside RUN; the result is ignored then anyway.
        bus.fma_x         = (state == RUN) ? bus.in_x : 16'h0000;
        bus.fma_y         = (state == RUN) ? bus.in_y : 16'h0000;
        bus.fma_z         = acc;
        bus.fma_mul       = 1'b1;
        bus.fma_add       = 1'b1;
        bus.fma_negp      = neg_r;
        bus.fma_negz      = 1'b0;
        bus.fma_roundmode = rm_r;
    end
endmodule

// File: tb/tb_fma16_dot_seq.sv
// Bench for fma16_dot_seq. A table-driven fma16 stand-in answers the datapath
// pins; expected job results go into a scoreboard queue at start and are
// popped when out_valid is seen.
module tb_fma16_dot_seq;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fma16_dot_seq_if #(.LEN_W(LEN_W)) bus ();

    fma16_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    logic [19:0] exp_q[$];
    logic [19:0] exp;

    // fma16 stand-in: known products for the vectors used here; x*y=0 returns z.
    // Anything else answers NaN/invalid so a wrong operand shows up downstream.
    function automatic logic [19:0] fma_model(input logic [15:0] x, y, z, input logic negp);
        case ({x, y, z, negp})
            {16'h3C00, 16'h4000, 16'h0000, 1'b0}: return {16'h4000, 4'b0000}; // 0+1*2
            {16'h4000, 16'h4000, 16'h4000, 1'b0}: return {16'h4600, 4'b0000}; // 2+2*2
            {16'h3C00, 16'h3C00, 16'h4200, 1'b1}: return {16'h4000, 4'b0000}; // 3-1*1
            {16'h7BFF, 16'h4000, 16'h0000, 1'b0}: return {16'h7C00, 4'b0101}; // overflow, RNE
            {16'h3C00, 16'h3C00, 16'h3C00, 1'b0}: return {16'h4000, 4'b0000}; // 1+1*1
            {16'h3C00, 16'h3C00, 16'h4600, 1'b0}: return {16'h4700, 4'b0000}; // 6+1*1
            default: begin
                if (x == 16'h0000 && y == 16'h0000) return {z, 4'b0000};
                return {16'h7E00, 4'b1000};
            end
        endcase
    endfunction

    always_comb {bus.fma_result, bus.fma_flags} =
        fma_model(bus.fma_x, bus.fma_y, bus.fma_z, bus.fma_negp);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.len = '0; bus.init = 16'h0000;
        bus.roundmode_in = 2'b00; bus.neg_in = 1'b0;
        bus.in_valid = 1'b0; bus.in_x = 16'h0000; bus.in_y = 16'h0000;
        bus.out_ready = 1'b0;
    endtask

    // Drives a start pulse for one cycle; the first pair may already be on the bus.
    task automatic do_start(input logic [LEN_W-1:0] l, input logic [15:0] i,
                            input logic [1:0] rm, input logic n);
        bus.len = l; bus.init = i; bus.roundmode_in = rm; bus.neg_in = n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        checks++; if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000)
            $display("FAIL reset_ctrl: got rdy/vld/busy=%b want 000", {bus.in_ready, bus.out_valid, bus.busy}); else passes++;
        checks++; if ({bus.out_result, bus.out_flags} !== 20'h0)
            $display("FAIL reset_out: got %h/%b want 0000/0000", bus.out_result, bus.out_flags); else passes++;
        reset = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0)
            $display("FAIL reset_release_busy: got %b want 0", bus.busy); else passes++;
    endtask

    task automatic test_basic();
        exp_q.push_back({16'h4600, 4'b0000});
        bus.in_valid = 1'b1; bus.in_x = 16'h3C00; bus.in_y = 16'h4000;
        do_start(8'd2, 16'h0000, 2'b01, 1'b0);
        checks++; if ({bus.in_ready, bus.fma_x, bus.fma_y, bus.fma_z} !== {1'b1, 16'h3C00, 16'h4000, 16'h0000})
            $display("FAIL basic_ops: got rdy=%b x=%h y=%h z=%h want 1 3c00 4000 0000", bus.in_ready, bus.fma_x, bus.fma_y, bus.fma_z); else passes++;
        checks++; if ({bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz, bus.fma_roundmode} !== 6'b1100_01)
            $display("FAIL basic_pins: got mul/add/negp/negz/rm=%b want 110001", {bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz, bus.fma_roundmode}); else passes++;
        tick();
        bus.in_x = 16'h4000; bus.in_y = 16'h4000;
        checks++; if ({bus.fma_z, bus.out_valid} !== {16'h4000, 1'b0})
            $display("FAIL basic_acc1: got z=%h vld=%b want 4000 0", bus.fma_z, bus.out_valid); else passes++;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1)
            $display("FAIL basic_latency: got out_valid=%b want 1 at 3 cycles", bus.out_valid); else passes++;
        exp = exp_q.pop_front();
        checks++; if ({bus.out_result, bus.out_flags} !== exp)
            $display("FAIL basic_result: got %h/%b want %h/%b", bus.out_result, bus.out_flags, exp[19:4], exp[3:0]); else passes++;
        checks++; if ({bus.fma_x, bus.fma_y} !== 32'h0)
            $display("FAIL basic_ops_done: got x=%h y=%h want 0000 0000", bus.fma_x, bus.fma_y); else passes++;
        handshake();
        checks++; if ({bus.out_valid, bus.busy} !== 2'b00)
            $display("FAIL basic_drop: got vld/busy=%b want 00", {bus.out_valid, bus.busy}); else passes++;
    endtask

    task automatic test_len0();
        exp_q.push_back({16'h4200, 4'b0000});
        bus.in_valid = 1'b1; bus.in_x = 16'h3C00; bus.in_y = 16'h3C00;
        checks++; if (bus.in_ready !== 1'b0)
            $display("FAIL len0_idle_rdy: got %b want 0", bus.in_ready); else passes++;
        do_start(8'd0, 16'h4200, 2'b01, 1'b0);
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10)
            $display("FAIL len0_latency: got vld/rdy=%b want 10", {bus.out_valid, bus.in_ready}); else passes++;
        exp = exp_q.pop_front();
        checks++; if ({bus.out_result, bus.out_flags} !== exp)
            $display("FAIL len0_result: got %h/%b want %h/%b", bus.out_result, bus.out_flags, exp[19:4], exp[3:0]); else passes++;
        handshake();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_neg();
        exp_q.push_back({16'h4000, 4'b0000});
        bus.in_valid = 1'b1; bus.in_x = 16'h3C00; bus.in_y = 16'h3C00;
        do_start(8'd1, 16'h4200, 2'b01, 1'b1);
        bus.neg_in = 1'b0;
        checks++; if ({bus.in_ready, bus.fma_negp} !== 2'b11)
            $display("FAIL neg_negp: got rdy/negp=%b want 11", {bus.in_ready, bus.fma_negp}); else passes++;
        tick();
        bus.in_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++; if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, exp})
            $display("FAIL neg_result: got vld=%b %h/%b want 1 %h/%b", bus.out_valid, bus.out_result, bus.out_flags, exp[19:4], exp[3:0]); else passes++;
        handshake();
    endtask

    task automatic test_rne_flags();
        exp_q.push_back({16'h7C00, 4'b0101});
        bus.in_valid = 1'b1; bus.in_x = 16'h7BFF; bus.in_y = 16'h4000;
        do_start(8'd1, 16'h0000, 2'b01, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++; if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, exp})
            $display("FAIL rne_result: got vld=%b %h/%b want 1 %h/%b", bus.out_valid, bus.out_result, bus.out_flags, exp[19:4], exp[3:0]); else passes++;
        handshake();
        // Next job must start with clean flags.
        exp_q.push_back({16'h4000, 4'b0000});
        bus.in_valid = 1'b1; bus.in_x = 16'h3C00; bus.in_y = 16'h3C00;
        do_start(8'd1, 16'h3C00, 2'b01, 1'b0);
        checks++; if (bus.out_flags !== 4'b0000)
            $display("FAIL rne_flags_cleared: got %b want 0000", bus.out_flags); else passes++;
        tick();
        bus.in_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++; if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, exp})
            $display("FAIL rne_next_result: got vld=%b %h/%b want 1 %h/%b", bus.out_valid, bus.out_result, bus.out_flags, exp[19:4], exp[3:0]); else passes++;
        handshake();
    endtask

    task automatic test_backpressure();
        logic [15:0] px[3] = '{16'h3C00, 16'h4000, 16'h3C00};
        logic [15:0] py[3] = '{16'h4000, 16'h4000, 16'h3C00};
        logic [4:0]  vpat = 5'b10101;
        int k = 0;
        exp_q.push_back({16'h4700, 4'b0000});
        do_start(8'd3, 16'h0000, 2'b01, 1'b0);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = vpat[4-c];
            bus.in_x = (k < 3) ? px[k] : 16'h0000;
            bus.in_y = (k < 3) ? py[k] : 16'h0000;
            // Stray start in a RUN gap must not disturb the job.
            if (c == 1) begin
                bus.start = 1'b1; bus.len = 8'd5; bus.init = 16'h1234; bus.neg_in = 1'b1;
            end
            checks++; if (bus.busy !== 1'b1)
                $display("FAIL bp_busy_run: cycle %0d got %b want 1", c, bus.busy); else passes++;
            if (bus.in_valid && bus.in_ready) k++;
            tick();
            bus.start = 1'b0; bus.neg_in = 1'b0;
        end
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, k[3:0]} !== {1'b1, 4'd3})
            $display("FAIL bp_accepts: got vld=%b accepts=%0d want 1 3", bus.out_valid, k); else passes++;
        exp = exp_q.pop_front();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) bus.start = 1'b1;
            checks++; if ({bus.out_valid, bus.busy, bus.out_result, bus.out_flags} !== {2'b11, exp})
                $display("FAIL bp_hold: cycle %0d got vld/busy=%b %h/%b want 11 %h/%b", c, {bus.out_valid, bus.busy}, bus.out_result, bus.out_flags, exp[19:4], exp[3:0]); else passes++;
            tick();
            bus.start = 1'b0;
        end
        // start together with out_ready in DONE: return to IDLE only.
        bus.start = 1'b1; bus.len = 8'd1;
        handshake();
        bus.start = 1'b0;
        checks++; if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b000)
            $display("FAIL bp_start_with_ready: got vld/busy/rdy=%b want 000", {bus.out_valid, bus.busy, bus.in_ready}); else passes++;
    endtask

    task automatic test_max_len();
        int n = 0;
        int k = 0;
        exp_q.push_back({16'h3C00, 4'b0000});
        bus.in_valid = 1'b1; bus.in_x = 16'h0000; bus.in_y = 16'h0000;
        do_start(8'hFF, 16'h3C00, 2'b01, 1'b0);
        n = 1;
        while (!bus.out_valid && n < 400) begin
            if (bus.in_valid && bus.in_ready) k++;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, k, n} !== {1'b1, 32'd255, 32'd256})
            $display("FAIL maxlen_count: got vld=%b accepts=%0d cycles=%0d want 1 255 256", bus.out_valid, k, n); else passes++;
        exp = exp_q.pop_front();
        checks++; if ({bus.out_result, bus.out_flags} !== exp)
            $display("FAIL maxlen_result: got %h/%b want %h/%b", bus.out_result, bus.out_flags, exp[19:4], exp[3:0]); else passes++;
        handshake();
    endtask

    task automatic test_reset_abort();
        exp_q.push_back({16'h7000, 4'b0000});
        bus.in_valid = 1'b1; bus.in_x = 16'h3C00; bus.in_y = 16'h4000;
        do_start(8'd3, 16'h0000, 2'b01, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b000)
            $display("FAIL abort_async: got busy/rdy/vld=%b want 000", {bus.busy, bus.in_ready, bus.out_valid}); else passes++;
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        exp_q.push_back({16'h4000, 4'b0000});
        bus.in_valid = 1'b1; bus.in_x = 16'h3C00; bus.in_y = 16'h3C00;
        do_start(8'd1, 16'h3C00, 2'b01, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++; if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, exp})
            $display("FAIL abort_next_result: got vld=%b %h/%b want 1 %h/%b", bus.out_valid, bus.out_result, bus.out_flags, exp[19:4], exp[3:0]); else passes++;
        handshake();
        checks++; if (exp_q.size() !== 0)
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_neg();
        test_rne_flags();
        test_backpressure();
        test_max_len();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
